// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   size_e   - access size encoding (byte, half, word)
//   state_e  - LSU control FSM states
//   decode_size   - maps the raw 2-bit core size field onto size_e (3 -> word)
//   is_misaligned - natural-alignment check for a given size and low address bits
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_e;

  // The core encodes size in two bits; the unused code 3 behaves as a word.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the LSU.
//   size, addr_lo   - access size and byte offset within the word
//   wen             - 1 = store (enables the write strobe), 0 = load
//   wdata           - right-aligned store data from the core
//   rdata           - full aligned word returned by memory
//   is_unsigned     - zero-extend instead of sign-extend narrow loads
//   wmask           - byte-lane write strobe (0 for loads)
//   wdata_sh        - store data shifted onto its byte lanes
//   rdata_ext       - selected load lane, truncated and extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        is_unsigned,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shamt;
  logic [31:0] lane;

  // Byte offset expressed as a bit shift amount.
  assign shamt    = {addr_lo, 3'b000};
  assign lane     = rdata >> shamt;
  assign wdata_sh = wdata << shamt;

  always_comb begin
    wmask     = 4'b0000;
    rdata_ext = lane;
    case (size)
      SZ_B: begin
        wmask     = 4'b0001 << addr_lo;
        rdata_ext = is_unsigned ? {24'h000000, lane[7:0]}
                                : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        wmask     = 4'b0011 << addr_lo;
        rdata_ext = is_unsigned ? {16'h0000, lane[15:0]}
                                : {{16{lane[15]}}, lane[15:0]};
      end
      default: begin
        // Words are only ever issued aligned, so the lane is the whole word.
        wmask     = 4'b1111;
        rdata_ext = lane;
      end
    endcase
    if (!wen) begin
      wmask = 4'b0000;
    end
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the core pipeline and a word-wide memory port.
//   clk, rst      - clock; asynchronous active-low reset
//   req_*         - core request (valid/ready), store flag, byte address,
//                   right-aligned store data, size, unsigned-load flag
//   resp_*        - core response (valid/ready), extended load data, misalign error
//   mem_*         - memory request (valid/ready) with write flag, word address,
//                   lane-shifted data and byte strobe; mem_rvalid/mem_rdata return reads
//   state_dbg     - current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are 1. A producer holding valid keeps its payload stable until that edge;
// ready may change freely and never depends on the transfer it completes.
// mem_rvalid has no ready: it is a one-cycle data strobe, honoured only in WAIT_R.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output state_e            state_dbg
);

  state_e      state_q, state_d;
  logic        wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;
  size_e       size_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_misaligned;
  logic [3:0]  lane_wmask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // Alignment is judged on the live request so a misaligned access never
  // reaches REQ and therefore never touches memory.
  assign req_misaligned = is_misaligned(decode_size(req_size), req_addr[1:0]);
  assign accept         = (state_q == IDLE) && req_valid;
  assign state_dbg      = state_q;

  lsu_align u_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .wen         (wen_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .is_unsigned (uns_q),
    .wmask       (lane_wmask),
    .wdata_sh    (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    mem_wmask  = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_misaligned ? RESP : REQ;
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        mem_wen   = wen_q;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = wen_q ? lane_wdata : 32'h0;
        mem_wmask = lane_wmask;
        if (mem_ready) begin
          state_d = wen_q ? RESP : WAIT_R;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        // Returning to IDLE means the next request is taken a cycle later.
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request fields and the response payload. rdata_q is cleared on accept so
  // stores and misaligned accesses answer with zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= decode_size(req_size);
        uns_q   <= req_unsigned;
        rdata_q <= 32'h0;
        err_q   <= req_misaligned;
      end else if ((state_q == WAIT_R) && mem_rvalid) begin
        rdata_q <= lane_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
module tb_lsu;
  import lsu_pkg::*;

  localparam int MW = 69;  // {wen, wmask, addr, wdata}
  localparam int RW = 33;  // {err, rdata}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  state_e      state_dbg;

  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [MW-1:0] exp_mem_q[$];
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // observations of the current transaction, for hand-computed checks
  int          obs_mem_cycles;
  int          obs_hs;
  int          obs_lat;
  logic [3:0]  obs_wmask;
  logic [31:0] obs_wdata;
  logic [31:0] obs_addr;
  logic        obs_wen;
  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // An access is legal when its address is a multiple of its size.
  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % m_nbytes(sz)) != 0;
  endfunction

  // Lanes covered by the access: offset .. offset+nbytes-1.
  function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m;
    int unsigned off;
    off = a % 4;
    m = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off + m_nbytes(sz))) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [31:0] a);
    longint unsigned v;
    v = longint'(wd) * (64'd1 << (8 * (a % 4)));
    return v[31:0];
  endfunction

  // Gather the addressed bytes little-endian, then extend as a number.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] sz, input logic uns);
    longint unsigned v;
    int unsigned n;
    int unsigned off;
    n = m_nbytes(sz);
    off = a % 4;
    v = 0;
    for (int i = 0; i < int'(n); i++)
      v = v + (longint'((rd >> (8 * (off + i))) & 32'hFF) << (8 * i));
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (mem_valid) begin
        check("mem_expected", exp_mem_q.size() > 0, 1);
        if (exp_mem_q.size() > 0) begin
          check("mem_wen",   mem_wen,   exp_mem_q[0][68]);
          check("mem_wmask", mem_wmask, exp_mem_q[0][67:64]);
          check("mem_addr",  mem_addr,  exp_mem_q[0][63:32]);
          check("mem_wdata", mem_wdata, exp_mem_q[0][31:0]);
          if (mem_ready) void'(exp_mem_q.pop_front());
        end
        if (obs_mem_cycles == 0) begin
          obs_wmask = mem_wmask; obs_wdata = mem_wdata;
          obs_addr  = mem_addr;  obs_wen   = mem_wen;
        end
        obs_mem_cycles++;
        if (mem_ready) obs_hs++;
      end else begin
        check("idle_mem_wen",   mem_wen,   0);
        check("idle_mem_wmask", mem_wmask, 0);
      end
      if (resp_valid) begin
        check("resp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("resp_rdata", resp_rdata, exp_q[0][31:0]);
          check("resp_err",   resp_err,   exp_q[0][32]);
          if (resp_ready) void'(exp_q.pop_front());
        end
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
      end
      if (mem_valid || resp_valid) check("busy_req_ready", req_ready, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_err"},   resp_err,   0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_mem_valid"},  mem_valid,  0);
    check({tag, "_mem_wen"},    mem_wen,    0);
    check({tag, "_mem_wmask"},  mem_wmask,  0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_wdata"},  mem_wdata,  0);
    check({tag, "_req_ready"},  req_ready,  1);
  endtask

  // One complete transaction: stall = cycles of mem_ready low in REQ,
  // rdelay = cycles before mem_rvalid, hold = cycles of resp_ready low.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sz, input logic uns, input int stall,
                         input logic [31:0] rd, input int rdelay, input int hold);
    bit mis;
    int k0;
    int guard;
    mis = m_misaligned(sz, addr);
    obs_mem_cycles = 0; obs_hs = 0; obs_lat = -1;
    obs_wmask = 'x; obs_wdata = 'x; obs_addr = 'x; obs_wen = 1'bx;
    obs_rdata = 'x; obs_err = 1'bx;
    if (!mis)
      exp_mem_q.push_back({wen, wen ? m_mask(sz, addr) : 4'h0, addr[31:2], 2'b00,
                           wen ? m_wdata(wdata, addr) : 32'h0});
    exp_q.push_back({mis, (wen || mis) ? 32'h0 : m_load(rd, addr, sz, uns)});

    guard = 0;
    while (!req_ready && guard < 20) begin tick(); guard++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = sz; req_unsigned = uns;
    mem_ready = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
    k0 = cyc;
    tick();
    // scramble the request bus so only latched fields can be used
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_wen = 1'($urandom_range(0, 1));
    if (!mis) begin
      for (int i = 0; i < stall; i++) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000 ^ i;  // must be ignored in REQ
        tick();
      end
      mem_rvalid = 1'b0; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      if (!wen) begin
        for (int i = 0; i < rdelay; i++) tick();
        mem_rvalid = 1'b1; mem_rdata = rd;
        tick();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    guard = 0;
    while (!resp_valid && guard < 50) begin tick(); guard++; end
    check("resp_arrives", resp_valid, 1);
    obs_lat = cyc - k0;
    for (int i = 0; i < hold; i++) begin
      check("hold_resp_valid", resp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("after_resp_valid", resp_valid, 0);
    check("after_req_ready", req_ready, 1);
    check("resp_q_drained", exp_q.size(), 0);
    check("mem_q_drained", exp_mem_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic wen; logic [31:0] addr; logic [31:0] wdata; logic [1:0] sz; logic uns;
    int stall; logic [31:0] rd; int rdelay; int hold;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #1;
    check_idle_outputs("rst_hold");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("rst_release");

    // store byte into the top lane
    run_txn(1'b1, 32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0, 0, 32'h0, 0, 0);
    check("v039_wmask", obs_wmask, 4'b1000);
    check("v039_wdata", obs_wdata, 32'hAB00_0000);
    check("v039_addr",  obs_addr,  32'h8000_0000);
    check("v039_wen",   obs_wen,   1'b1);
    check("v039_lat",   obs_lat,   2);

    // signed and unsigned half loads from the upper half
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 0, 32'h8001_1234, 0, 0);
    check("v040s_rdata", obs_rdata, 32'hFFFF_8001);
    check("v040s_lat",   obs_lat,   3);
    check("v040s_wmask", obs_wmask, 4'b0000);
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 0, 32'h8001_1234, 0, 0);
    check("v040u_rdata", obs_rdata, 32'h0000_8001);

    // misaligned word load: error response, no memory traffic
    run_txn(1'b0, 32'h8000_0006, 32'h0, 2'd2, 1'b0, 0, 32'h1111_1111, 0, 0);
    check("v041_err",   obs_err,        1'b1);
    check("v041_rdata", obs_rdata,      32'h0);
    check("v041_mem",   obs_mem_cycles, 0);

    // memory stalls five cycles
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 5, 32'h0, 0, 0);
    check("v042_cycles", obs_mem_cycles, 6);
    check("v042_hs",     obs_hs,         1);
    check("v042_wmask",  obs_wmask,      4'b1111);

    // core stalls the response three cycles
    run_txn(1'b0, 32'h0000_0101, 32'h0, 2'd0, 1'b0, 0, 32'h1234_80FF, 1, 3);
    check("v043_rdata", obs_rdata, 32'hFFFF_FF80);

    vecs[0] = '{1'b1, 32'h0000_0006, 32'h0000_CAFE, 2'd1, 1'b0, 1, 32'h0, 0, 0};
    vecs[1] = '{1'b0, 32'h0000_0003, 32'h0, 2'd0, 1'b1, 0, 32'h9A00_0000, 2, 1};
    vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_1234, 2'd1, 1'b0, 0, 32'h0, 0, 2};
    vecs[3] = '{1'b0, 32'h0000_0008, 32'h0, 2'd3, 1'b0, 2, 32'h8765_4321, 0, 0};
    vecs[4] = '{1'b1, 32'h0000_0001, 32'hFFFF_FF12, 2'd0, 1'b0, 0, 32'h0, 0, 0};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0, 2'd1, 1'b0, 0, 32'h0000_7FFF, 3, 0};
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].sz, vecs[i].uns,
              vecs[i].stall, vecs[i].rd, vecs[i].rdelay, vecs[i].hold);
    check("v_size3_rdata", obs_rdata, 32'h7FFF);  // last vector
    check("v_last_lat",    obs_lat,   6);

    // reset while waiting for read data; stale rvalid afterwards is ignored
    exp_mem_q.push_back({1'b0, 4'h0, 32'h0000_0040, 32'h0});
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h40; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h5555_5555; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_wait_r");
    exp_q.delete(); exp_mem_q.delete();
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_idle_outputs("post_rst_wait_r");
      tick();
    end

    // reset while the memory request is pending: it must not be reissued
    exp_mem_q.push_back({1'b1, 4'hF, 32'h0000_0080, 32'h0BAD_F00D});
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80; req_size = 2'd2;
    req_wdata = 32'h0BAD_F00D; mem_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check("rst_req_mem_valid", mem_valid, 1);
    tick();
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_req");
    exp_q.delete(); exp_mem_q.delete();
    tick();
    rst = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_outputs("post_rst_req");
    end
    mem_ready = 1'b0;

    // normal traffic resumes after the aborted transactions
    run_txn(1'b0, 32'h0000_0002, 32'h0, 2'd0, 1'b0, 0, 32'h0055_0000, 0, 0);
    check("resume_rdata", obs_rdata, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: ADDR_W, 32, address width of core and memory ports.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset is asynchronous and active-low.
REQ-004 req_valid  input  1  core requests a load/store.
REQ-005 req_ready  output  1  LSU accepts a request this cycle.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  ADDR_W  byte address, i.e. ALU result.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-010 req_unsigned  input  1  zero-extend load (lbu/lhu).
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  core takes response.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned access.
REQ-015 mem_valid  output  1  memory request.
REQ-016 mem_ready  input  1  memory accepts request.
REQ-017 mem_wen  output  1  memory write.
REQ-018 mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
REQ-019 mem_wdata  output  32  lane-shifted store data.
REQ-020 mem_wmask  output  4  byte-lane write strobe.
REQ-021 mem_rvalid  input  1  read data valid.
REQ-022 mem_rdata  input  32  full aligned word.

Function
REQ-023 FSM states SHALL be IDLE, REQ, WAIT_R, RESP; req_ready SHALL be 1 only in IDLE.
REQ-024 IDLE, on req_valid: latch wen, addr, wdata, size and unsigned; go to REQ if aligned, else go to RESP with resp_err=1.
REQ-025 Misaligned SHALL be defined as half with addr[0]=1, or word with addr[1:0]!=0; no memory access SHALL be issued for it.
REQ-026 REQ: mem_valid=1 with mem_wen, mem_addr, mem_wdata and mem_wmask held stable until the cycle with mem_ready=1.
REQ-027 On the REQ handshake, a store SHALL go to RESP and a load SHALL go to WAIT_R.
REQ-028 WAIT_R: mem_rvalid SHALL be sampled only in this state (earliest the cycle after handshake); on mem_rvalid, capture extracted data and go to RESP.
REQ-029 RESP: resp_valid=1 and resp_rdata/resp_err held until resp_ready=1, then go to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-030 Store mask SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, 4'b1111 for word; mem_wdata SHALL be req_wdata<<(8*addr[1:0]) with the upper bits truncated.
REQ-031 Load data SHALL be the selected lane (mem_rdata>>(8*addr[1:0])) truncated to size, then sign-extended, or zero-extended when unsigned; word is passed through.
REQ-032 mem_wmask SHALL be 0 and mem_wen SHALL be 0 for loads.
REQ-033 Outside REQ, mem_valid SHALL be 0 and mem_wen/mem_wmask SHALL be 0.
REQ-034 Minimum latency: store with immediate mem_ready is 2 cycles from accept to resp_valid; load with rvalid the cycle after handshake is 3 cycles.

Reset
REQ-035 rst=0 SHALL asynchronously force IDLE and clear all latched fields; resp_valid, resp_err, resp_rdata, mem_valid, mem_wen, mem_wmask, mem_addr and mem_wdata SHALL all be 0, and req_ready SHALL be 1 once rst deasserts.
REQ-036 Reset mid-transaction SHALL abort it without reissue; a stale mem_rvalid after reset in IDLE SHALL be ignored.

Structure
REQ-037 Package lsu_pkg SHALL hold the size encoding enum (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-038 Lane logic (mask, shift and extension) SHALL be a combinational sub-module lsu_align; lsu holds only the FSM and registers.

Verification
REQ-039 Store byte addr=0x80000003 wdata=0x000000AB, mem_ready immediate -> mem_wmask=4'b1000, mem_wdata=0xAB000000, mem_addr=0x80000000, resp_valid 2 cycles after accept.
REQ-040 Load half addr=0x80000002 signed, mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001; with unsigned -> 0x00008001.
REQ-041 Load word addr=0x80000006 -> resp_err=1, resp_rdata=0, mem_valid never asserted.
REQ-042 mem_ready held low 5 cycles -> mem_valid/address/data stable for all 6 cycles, single handshake.
REQ-043 resp_ready low 3 cycles in RESP -> resp_valid and data held, req_ready=0 throughout.
REQ-044 rst low while in WAIT_R, then mem_rvalid=1 after release -> IDLE, resp_valid stays 0, outputs 0.
